debug_scan_mux: RTL

Registered, parametrised debug-readout selector for the pipelined CPU board. It maps switch-selected channels onto arbitrary register-file entries or the PC through a build-time channel map. It adds an auto-scan mode that steps through channels on a dwell timer, a freeze toggle that holds the display, and a change-detect pulse. It sits between the register file / PC and the board's seven-segment/LED display driver.

---
 rtl/debug_scan_mux_if.sv | 29 ++
 rtl/debug_scan_mux.sv | 122 ++++++++++++
 2 files changed

// File: rtl/debug_scan_mux_if.sv
// Debug readout bundle between the register-file/PC taps and the display selector.
// master drives the taps and board controls, slave (the selector) drives the display fields.
// Widths follow the selector's DATA_W / NREGS / SEL_W parameters.
interface debug_scan_mux_if #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int SEL_W  = 4
);
   logic [SEL_W-1:0]              sel;
   logic                          scan_en;
   logic                          freeze_req;
   logic [NREGS-1:0][DATA_W-1:0]  regs;
   logic [DATA_W-1:0]             dbg_pc;
   logic [DATA_W-1:0]             dbg_data;
   logic [SEL_W-1:0]              dbg_ch;
   logic                          dbg_valid;
   logic                          dbg_frozen;
   logic                          dbg_chg;

   modport master (
      output sel, scan_en, freeze_req, regs, dbg_pc,
      input  dbg_data, dbg_ch, dbg_valid, dbg_frozen, dbg_chg
   );

   modport slave (
      input  sel, scan_en, freeze_req, regs, dbg_pc,
      output dbg_data, dbg_ch, dbg_valid, dbg_frozen, dbg_chg
   );
endinterface

// File: rtl/debug_scan_mux.sv
// Debug readout selector: maps a manual or auto-scanned channel onto a register or the PC.
// Latency: 1 cycle from sel/regs/dbg_pc to dbg_data; dbg_chg aligned with the changed data.
// No backpressure: a freeze toggle holds the display and pauses the scan counters.
module debug_scan_mux #(
   parameter int                  DATA_W   = 32,
   parameter int                  NREGS    = 32,
   parameter int                  NCH      = 8,
   parameter int                  SEL_W    = 4,
   parameter int                  IDX_W    = $clog2(NREGS) + 1,
   parameter logic [NCH*IDX_W-1:0] CH_MAP  = {IDX_W'(32), IDX_W'(31), IDX_W'(12), IDX_W'(11),
                                              IDX_W'(10), IDX_W'(9),  IDX_W'(8),  IDX_W'(0)},
   parameter int                  DWELL    = 50_000_000,
   parameter logic [DATA_W-1:0]   DEAD_VAL = 32'hDEADBEEF
) (
   input logic              clk,
   input logic              rst_n,
   debug_scan_mux_if.slave  bus
);
   localparam int DW_W = $clog2(DWELL + 1);

   logic              scan_en_q;
   logic              frozen;
   logic [SEL_W-1:0]  scan_ch;
   logic [SEL_W-1:0]  scan_ch_nxt;
   logic [DW_W-1:0]   dwell_cnt;
   logic [DW_W-1:0]   dwell_nxt;
   logic              hold;
   logic              scan_rise;
   logic [SEL_W-1:0]  ch_nxt;
   logic [IDX_W-1:0]  entry;
   logic [DATA_W-1:0] val_nxt;
   logic              valid_nxt;
   logic [DATA_W-1:0] data_q;
   logic [SEL_W-1:0]  ch_q;
   logic              valid_q;
   logic              chg_q;

   // A freeze pulse takes effect in its own cycle, so it also wins over dwell expiry
   // and a same-cycle scan_en edge; the unfreeze cycle is held as well.
   assign hold      = frozen | bus.freeze_req;
   assign scan_rise = bus.scan_en & ~scan_en_q;

   // Next scan position; the display registers the next value so channel 0 shows
   // one cycle after the scan_en edge and each channel lasts exactly DWELL cycles.
   always_comb begin
      scan_ch_nxt = scan_ch;
      dwell_nxt   = dwell_cnt;
      if (!hold) begin
         if (!bus.scan_en || scan_rise) begin
            scan_ch_nxt = '0;
            dwell_nxt   = '0;
         end else if (dwell_cnt == DW_W'(DWELL - 1)) begin
            dwell_nxt   = '0;
            scan_ch_nxt = (scan_ch == SEL_W'(NCH - 1)) ? '0 : scan_ch + 1'b1;
         end else begin
            dwell_nxt   = dwell_cnt + 1'b1;
         end
      end
   end

   assign ch_nxt = bus.scan_en ? scan_ch_nxt : bus.sel;

   // Channel map lookup: unmapped channels show DEAD_VAL, map entries past the
   // register file select the PC.
   always_comb begin
      entry     = '0;
      val_nxt   = DEAD_VAL;
      valid_nxt = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (ch_nxt == SEL_W'(i)) begin
            entry     = CH_MAP[i*IDX_W +: IDX_W];
            valid_nxt = 1'b1;
         end
      end
      if (valid_nxt) begin
         val_nxt = bus.dbg_pc;
         for (int r = 0; r < NREGS; r++) begin
            if (entry == IDX_W'(r)) begin
               val_nxt = bus.regs[r];
            end
         end
      end
   end

   // Freeze toggle, scan_en edge tracking (runs even while frozen) and scan counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_en_q <= 1'b0;
         frozen    <= 1'b0;
         scan_ch   <= '0;
         dwell_cnt <= '0;
      end else begin
         scan_en_q <= bus.scan_en;
         frozen    <= frozen ^ bus.freeze_req;
         scan_ch   <= scan_ch_nxt;
         dwell_cnt <= dwell_nxt;
      end
   end

   // Display registers; a change pulse only fires when the channel stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         chg_q   <= 1'b0;
      end else if (hold) begin
         chg_q   <= 1'b0;
      end else begin
         data_q  <= val_nxt;
         ch_q    <= ch_nxt;
         valid_q <= valid_nxt;
         chg_q   <= (ch_nxt == ch_q) && (val_nxt != data_q);
      end
   end

   assign bus.dbg_data   = data_q;
   assign bus.dbg_ch     = ch_q;
   assign bus.dbg_valid  = valid_q;
   assign bus.dbg_frozen = frozen;
   assign bus.dbg_chg    = chg_q;
endmodule
